// File: rtl/pipelined_alu.sv
// Two-stage registered ALU with valid/ready handshake on both sides and per-result status flags.
// Optional signed saturation for ADD/SUB is enabled by defining PIPELINED_ALU_SAT_EN (adds port sat_en).
module pipelined_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
`ifdef PIPELINED_ALU_SAT_EN
    input  logic                  sat_en,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  flag_zero,
    output logic                  flag_neg,
    output logic                  flag_carry,
    output logic                  flag_ovf
);

    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_NOTA  = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_SLT   = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

`ifdef PIPELINED_ALU_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SIGNED_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    // Stage 1: captured operand bundle
    logic                  s1Valid_q, s1Valid_d;
    logic [DATA_WIDTH-1:0] s1A_q, s1A_d;
    logic [DATA_WIDTH-1:0] s1B_q, s1B_d;
    logic [2:0]            s1Op_q, s1Op_d;
`ifdef PIPELINED_ALU_SAT_EN
    logic                  s1Sat_q, s1Sat_d;
`endif

    // Stage 2: registered result and flags, driving the outputs directly
    logic                  s2Valid_q, s2Valid_d;
    logic [DATA_WIDTH-1:0] s2Result_q, s2Result_d;
    logic                  s2Zero_q, s2Zero_d;
    logic                  s2Neg_q, s2Neg_d;
    logic                  s2Carry_q, s2Carry_d;
    logic                  s2Ovf_q, s2Ovf_d;

    logic s2Advance;
    logic inFire;
    logic s1Fire;

    logic [DATA_WIDTH:0]   sumWide;
    logic [DATA_WIDTH:0]   diffWide;
    logic                  sumOvf;
    logic                  diffOvf;
    logic                  sltBit;
    logic [DATA_WIDTH-1:0] aluResult;
    logic                  aluCarry;
    logic                  aluOvf;

    // in_ready is forced low during reset so nothing is accepted into a clearing pipeline
    assign s2Advance = !s2Valid_q || out_ready;
    assign in_ready  = !reset && (!s1Valid_q || s2Advance);
    assign inFire    = in_valid && in_ready;
    assign s1Fire    = s1Valid_q && s2Advance;

    always_comb begin
        s1Valid_d = s1Valid_q;
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        s1Op_d    = s1Op_q;
`ifdef PIPELINED_ALU_SAT_EN
        s1Sat_d   = s1Sat_q;
`endif
        if (inFire) begin
            s1Valid_d = 1'b1;
            s1A_d     = a;
            s1B_d     = b;
            s1Op_d    = op;
`ifdef PIPELINED_ALU_SAT_EN
            s1Sat_d   = sat_en;
`endif
        end else if (s1Fire) begin
            s1Valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Op_q    <= '0;
`ifdef PIPELINED_ALU_SAT_EN
            s1Sat_q   <= 1'b0;
`endif
        end else begin
            s1Valid_q <= s1Valid_d;
            s1A_q     <= s1A_d;
            s1B_q     <= s1B_d;
            s1Op_q    <= s1Op_d;
`ifdef PIPELINED_ALU_SAT_EN
            s1Sat_q   <= s1Sat_d;
`endif
        end
    end

    // The extra top bit of the wide sum/difference is the carry-out / unsigned borrow
    assign sumWide  = {1'b0, s1A_q} + {1'b0, s1B_q};
    assign diffWide = {1'b0, s1A_q} - {1'b0, s1B_q};
    assign sumOvf   = (s1A_q[MSB] == s1B_q[MSB]) && (sumWide[MSB] != s1A_q[MSB]);
    assign diffOvf  = (s1A_q[MSB] != s1B_q[MSB]) && (diffWide[MSB] != s1A_q[MSB]);
    assign sltBit   = $signed(s1A_q) < $signed(s1B_q);

    always_comb begin
        aluResult = '0;
        aluCarry  = 1'b0;
        aluOvf    = 1'b0;
        case (s1Op_q)
            OP_ADD: begin
                aluResult = sumWide[MSB:0];
                aluCarry  = sumWide[DATA_WIDTH];
                aluOvf    = sumOvf;
            end
            OP_SUB: begin
                aluResult = diffWide[MSB:0];
                aluCarry  = diffWide[DATA_WIDTH];
                aluOvf    = diffOvf;
            end
            OP_NOTA:  aluResult = ~s1A_q;
            OP_AND:   aluResult = s1A_q & s1B_q;
            OP_OR:    aluResult = s1A_q | s1B_q;
            OP_XOR:   aluResult = s1A_q ^ s1B_q;
            OP_SLT:   aluResult = {{(DATA_WIDTH-1){1'b0}}, sltBit};
            OP_PASSB: aluResult = s1B_q;
            default:  aluResult = '0;
        endcase
`ifdef PIPELINED_ALU_SAT_EN
        // Overflow direction follows the sign of a: a non-negative a can only overflow upwards
        if (s1Sat_q && aluOvf) begin
            aluResult = s1A_q[MSB] ? SIGNED_MIN : SIGNED_MAX;
        end
`endif
    end

    always_comb begin
        s2Valid_d  = s2Valid_q;
        s2Result_d = s2Result_q;
        s2Zero_d   = s2Zero_q;
        s2Neg_d    = s2Neg_q;
        s2Carry_d  = s2Carry_q;
        s2Ovf_d    = s2Ovf_q;
        if (s2Advance) begin
            s2Valid_d = s1Valid_q;
        end
        if (s1Fire) begin
            s2Result_d = aluResult;
            s2Zero_d   = (aluResult == '0);
            s2Neg_d    = aluResult[MSB];
            s2Carry_d  = aluCarry;
            s2Ovf_d    = aluOvf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2Valid_q  <= 1'b0;
            s2Result_q <= '0;
            s2Zero_q   <= 1'b0;
            s2Neg_q    <= 1'b0;
            s2Carry_q  <= 1'b0;
            s2Ovf_q    <= 1'b0;
        end else begin
            s2Valid_q  <= s2Valid_d;
            s2Result_q <= s2Result_d;
            s2Zero_q   <= s2Zero_d;
            s2Neg_q    <= s2Neg_d;
            s2Carry_q  <= s2Carry_d;
            s2Ovf_q    <= s2Ovf_d;
        end
    end

    assign out_valid  = s2Valid_q;
    assign result     = s2Result_q;
    assign flag_zero  = s2Zero_q;
    assign flag_neg   = s2Neg_q;
    assign flag_carry = s2Carry_q;
    assign flag_ovf   = s2Ovf_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu at DATA_WIDTH=8: directed cases, stall/reset scenarios and
// a random stream checked against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_alu;

    localparam int DW = 8;
`ifdef PIPELINED_ALU_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          satEn;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          flag_zero;
    logic          flag_neg;
    logic          flag_carry;
    logic          flag_ovf;
    logic [11:0]   outVec;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;
    logic [11:0] expQ[$];
    logic [7:0]  drainLog[$];
    int          drainCyc[$];
    bit          lastAccepted;
    bit          prevStall = 1'b0;
    logic [11:0] held;

    always #5 clk = ~clk;

    assign outVec = {result, flag_zero, flag_neg, flag_carry, flag_ovf};

    pipelined_alu #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
`ifdef PIPELINED_ALU_SAT_EN
        .sat_en     (satEn),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_neg   (flag_neg),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf)
    );

    // Reference: integer arithmetic on the true unsigned/signed values, packed as {result,z,n,c,v}
    function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                          input logic s);
        int ux = int'(x);
        int uy = int'(y);
        int sx = (ux >= 128) ? ux - 256 : ux;
        int sy = (uy >= 128) ? uy - 256 : uy;
        int wide = 0;
        int sgn = 0;
        logic [7:0] r = 8'h00;
        bit c = 1'b0;
        bit v = 1'b0;
        case (o)
            3'd0: begin
                wide = ux + uy; sgn = sx + sy;
                r = 8'(wide); c = (wide > 255); v = (sgn > 127) || (sgn < -128);
            end
            3'd1: begin
                wide = ux - uy; sgn = sx - sy;
                r = 8'(wide); c = (ux < uy); v = (sgn > 127) || (sgn < -128);
            end
            3'd2: r = 8'(255 - ux);
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: r = (sx < sy) ? 8'd1 : 8'd0;
            default: r = y;
        endcase
        if (SAT_BUILD && s && v) r = (sgn > 0) ? 8'h7F : 8'h80;
        return {r, (r == 8'h00), r[7], c, v};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drives one cycle, scores the handshakes just before the rising edge
    task automatic applyStimulus(input logic iv, input logic [2:0] o, input logic [7:0] x,
                                 input logic [7:0] y, input logic s, input logic ordy);
        in_valid = iv; op = o; a = x; b = y; satEn = s; out_ready = ordy;
        #3;
        if (prevStall) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_hold", 32'(outVec), 32'(held));
        end
        prevStall = out_valid && !out_ready;
        held = outVec;
        if (out_valid && out_ready) begin
            checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) checkOutput("sb_data", 32'(outVec), 32'(expQ.pop_front()));
            drainLog.push_back(result);
            drainCyc.push_back(cycleNo);
        end
        lastAccepted = in_valid && in_ready;
        if (lastAccepted) expQ.push_back(model(o, x, y, s));
        @(posedge clk);
        cycleNo++;
        @(negedge clk);
    endtask

    task automatic doReset(input int n);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #3;
            checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk);
            cycleNo++;
            @(negedge clk);
        end
        reset = 1'b0;
        expQ.delete();
        prevStall = 1'b0;
        #1;
        checkOutput("rst_in_ready_high", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_outputs", 32'(outVec), 32'd0);
    endtask

    task automatic directedOp(input string tag, input logic [2:0] o, input logic [7:0] x,
                              input logic [7:0] y, input logic s, input logic [11:0] exp);
        applyStimulus(1'b1, o, x, y, s, 1'b1);
        checkOutput({tag, "_accept"}, 32'(lastAccepted), 32'd1);
        checkOutput({tag, "_lat1"}, 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput({tag, "_lat2"}, 32'(out_valid), 32'd1);
        checkOutput(tag, 32'(outVec), 32'(exp));
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [7:0] streamExp[8] = '{8'hE1, 8'h97, 8'hC3, 8'h24, 8'hBD, 8'h99, 8'h00, 8'hA5};
        int acc;
        int tries;

        reset = 1'b1; in_valid = 1'b0; op = 3'd0; a = '0; b = '0; satEn = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        doReset(2);

        directedOp("add_ff_01", 3'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 4'b1010});
        directedOp("sub_80_01", 3'd1, 8'h80, 8'h01, 1'b0, {8'h7F, 4'b0001});
`ifdef PIPELINED_ALU_SAT_EN
        directedOp("sub_80_01_sat", 3'd1, 8'h80, 8'h01, 1'b1, {8'h80, 4'b0101});
`endif
        directedOp("slt_fe_01", 3'd6, 8'hFE, 8'h01, 1'b0, {8'h01, 4'b0000});
        directedOp("sub_01_02", 3'd1, 8'h01, 8'h02, 1'b0, {8'hFF, 4'b0110});

        // Back-to-back stream of all opcodes
        drainLog.delete(); drainCyc.delete();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 8'h3C, 8'hA5, 1'b0, 1'b1);
            acc += int'(lastAccepted);
        end
        repeat (3) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("stream_accepts", 32'(acc), 32'd8);
        checkOutput("stream_count", 32'(drainLog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < drainLog.size()) begin
                checkOutput("stream_res", 32'(drainLog[i]), 32'(streamExp[i]));
                checkOutput("stream_consec", 32'(drainCyc[i] - drainCyc[0]), 32'(i));
            end
        end

        // Stall with three bundles offered
        drainLog.delete(); drainCyc.delete();
        acc = 0;
        applyStimulus(1'b1, 3'd0, 8'h10, 8'h20, 1'b0, 1'b0); acc += int'(lastAccepted);
        applyStimulus(1'b1, 3'd5, 8'h5A, 8'h0F, 1'b0, 1'b0); acc += int'(lastAccepted);
        applyStimulus(1'b1, 3'd7, 8'h11, 8'h77, 1'b0, 1'b0); acc += int'(lastAccepted);
        checkOutput("stall_accepts", 32'(acc), 32'd2);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (3) begin
            applyStimulus(1'b1, 3'd7, 8'h11, 8'h77, 1'b0, 1'b0);
            acc += int'(lastAccepted);
        end
        checkOutput("stall_still_two", 32'(acc), 32'd2);
        tries = 0;
        lastAccepted = 1'b0;
        while (!lastAccepted && tries < 10) begin
            applyStimulus(1'b1, 3'd7, 8'h11, 8'h77, 1'b0, 1'b1);
            tries++;
        end
        checkOutput("stall_release", 32'(lastAccepted), 32'd1);
        repeat (4) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("stall_drained", 32'(drainLog.size()), 32'd3);

        // Reset with both stages full: in-flight results must never appear
        applyStimulus(1'b1, 3'd0, 8'h01, 8'h02, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd4, 8'hF0, 8'h0F, 1'b0, 1'b0);
        checkOutput("full_before_rst", 32'(out_valid), 32'd1);
        doReset(1);
        repeat (4) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                          8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
        end
        repeat (5) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("final_empty", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
